// File: rtl/fan_countdown_if.sv
// rtl/fan_countdown_if.sv - tick, button and status signals between fan_countdown and its neighbours
interface fan_countdown_if #(
    parameter int CNT_W = 8
);
    logic             tick_1s;
    logic             tick_500ms;
    logic             tick_250ms;
    logic             fan_on;
    logic             btn_time;
    logic             btn_cancel;
    logic [CNT_W-1:0] remaining;
    logic             fan_off_req;
    logic             led;
    logic [1:0]       state;

    modport master (
        output tick_1s, tick_500ms, tick_250ms, fan_on, btn_time, btn_cancel,
        input  remaining, fan_off_req, led, state
    );

    modport slave (
        input  tick_1s, tick_500ms, tick_250ms, fan_on, btn_time, btn_cancel,
        output remaining, fan_off_req, led, state
    );
endinterface

// File: rtl/fan_countdown.sv
// rtl/fan_countdown.sv - auto-off countdown with preset cycling, warning flash and one-cycle fan-off request
module fan_countdown #(
    parameter int CNT_W    = 8,
    parameter int PRESET0  = 30,
    parameter int PRESET1  = 60,
    parameter int PRESET2  = 120,
    parameter int WARN_SEC = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    fan_countdown_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_WARN   = 2'd2,
        S_EXPIRE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] P0      = PRESET0[CNT_W-1:0];
    localparam logic [CNT_W-1:0] P1      = PRESET1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] P2      = PRESET2[CNT_W-1:0];
    localparam int               WARN_P1 = WARN_SEC + 1;
    localparam logic [CNT_W-1:0] WARN_AT = WARN_P1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [1:0]       sel_q, sel_d;
    logic             led_q, led_d;
    logic             req_q, req_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            sel_q       <= 2'd0;
            led_q       <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sel_q       <= sel_d;
            led_q       <= led_d;
            req_q       <= req_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sel_d       = sel_q;
        led_d       = led_q;
        req_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                led_d = 1'b0;
                if (!bus.btn_cancel && bus.fan_on && bus.btn_time) begin
                    sel_d       = 2'd0;
                    remaining_d = P0;
                    state_d     = S_RUN;
                    led_d       = 1'b1;
                end
            end
            S_RUN, S_WARN: begin
                // btn_time past the last preset behaves exactly like cancel
                if (bus.btn_cancel || !bus.fan_on || (bus.btn_time && sel_q == 2'd2)) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                    sel_d       = 2'd0;
                    led_d       = 1'b0;
                end else if (bus.btn_time) begin
                    sel_d       = sel_q + 2'd1;
                    remaining_d = (sel_q == 2'd0) ? P1 : P2;
                    state_d     = S_RUN;
                    led_d       = 1'b1;
                end else begin
                    if (state_q == S_RUN && bus.tick_500ms) led_d = ~led_q;
                    if (state_q == S_WARN && bus.tick_250ms) led_d = ~led_q;
                    if (bus.tick_1s && remaining_q != '0) begin
                        remaining_d = remaining_q - ONE;
                        if (remaining_q == ONE) begin
                            state_d = S_EXPIRE;
                            req_d   = 1'b1;
                        end else if (remaining_q == WARN_AT) begin
                            state_d = S_WARN;
                            led_d   = 1'b1;
                        end
                    end
                end
            end
            S_EXPIRE: begin
                state_d = S_IDLE;
                led_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.remaining   = remaining_q;
    assign bus.led         = led_q;
    assign bus.fan_off_req = req_q;
endmodule

// File: tb/tb_fan_countdown.sv
// tb/tb_fan_countdown.sv - randomized and directed checks of fan_countdown against a rule-level model
module tb_fan_countdown;
    localparam int WARN_SEC = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    int presets [3] = '{30, 60, 120};
    int m_state, m_rem, m_led, m_req, m_sel;
    int dut_req_cnt, mdl_req_cnt;

    fan_countdown_if #(.CNT_W(8)) bus ();

    fan_countdown #(
        .CNT_W(8), .PRESET0(30), .PRESET1(60), .PRESET2(120), .WARN_SEC(WARN_SEC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        m_req = 0;
        if (!rst_n) begin
            m_state = 0; m_rem = 0; m_led = 0; m_sel = 0;
        end else if (m_state == 3) begin
            m_state = 0; m_led = 0;
        end else if (m_state == 0) begin
            if (!bus.btn_cancel && bus.fan_on && bus.btn_time) begin
                m_sel = 0; m_rem = presets[0]; m_state = 1; m_led = 1;
            end
        end else begin
            if (bus.btn_cancel || !bus.fan_on || (bus.btn_time && m_sel == 2)) begin
                m_state = 0; m_rem = 0; m_sel = 0; m_led = 0;
            end else if (bus.btn_time) begin
                m_sel = m_sel + 1; m_rem = presets[m_sel]; m_state = 1; m_led = 1;
            end else begin
                if ((m_state == 1 && bus.tick_500ms) || (m_state == 2 && bus.tick_250ms))
                    m_led = 1 - m_led;
                if (bus.tick_1s && m_rem > 0) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_state = 3; m_req = 1;
                    end else if (m_rem == WARN_SEC) begin
                        m_state = 2; m_led = 1;
                    end
                end
            end
        end
        mdl_req_cnt += m_req;
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_step();
        #1;
        dut_req_cnt += int'(bus.fan_off_req);
        bus.tick_1s = 0; bus.tick_500ms = 0; bus.tick_250ms = 0;
        bus.btn_time = 0; bus.btn_cancel = 0;
    endtask

    task automatic arm();
        bus.fan_on = 1; bus.btn_time = 1;
        clk_step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int i = 0; i < 10; i++) begin
            bus.tick_1s = 1'($urandom); bus.tick_500ms = 1'($urandom);
            bus.tick_250ms = 1'($urandom); bus.fan_on = 1'($urandom);
            bus.btn_time = 1'($urandom); bus.btn_cancel = 1'($urandom);
            clk_step();
            n_cmp++;
            if (bus.state !== 2'd0 || bus.remaining !== 8'd0 || bus.led !== 1'b0 || bus.fan_off_req !== 1'b0) begin
                n_err++;
                $display("FAIL reset cyc%0d: state=%0d rem=%0d led=%b req=%b, want all 0",
                         i, bus.state, bus.remaining, bus.led, bus.fan_off_req);
            end
        end
        rst_n = 1;
        clk_step();
    endtask

    task automatic test_full_countdown();
        int req_before;
        int exp_state;
        arm();
        n_cmp++;
        if (bus.state !== 2'd1 || bus.remaining !== 8'd30) begin
            n_err++;
            $display("FAIL arm: state=%0d rem=%0d, want 1/30", bus.state, bus.remaining);
        end
        req_before = dut_req_cnt;
        for (int k = 1; k <= 30; k++) begin
            for (int g = 0; g < 19; g++) begin
                bus.tick_500ms = ($urandom_range(3) == 0);
                bus.tick_250ms = ($urandom_range(2) == 0);
                clk_step();
                n_cmp++;
                if (int'(bus.state) !== m_state || int'(bus.remaining) !== m_rem ||
                    int'(bus.led) !== m_led || int'(bus.fan_off_req) !== m_req) begin
                    n_err++;
                    $display("FAIL countdown gap k%0d: st=%0d rem=%0d led=%b req=%b, want %0d/%0d/%0d/%0d",
                             k, bus.state, bus.remaining, bus.led, bus.fan_off_req, m_state, m_rem, m_led, m_req);
                end
            end
            bus.tick_1s = 1;
            clk_step();
            exp_state = (k < 25) ? 1 : (k < 30) ? 2 : 3;
            n_cmp++;
            if (int'(bus.remaining) !== 30 - k || int'(bus.state) !== exp_state ||
                bus.fan_off_req !== (k == 30)) begin
                n_err++;
                $display("FAIL countdown tick%0d: rem=%0d st=%0d req=%b, want %0d/%0d/%b",
                         k, bus.remaining, bus.state, bus.fan_off_req, 30 - k, exp_state, k == 30);
            end
        end
        clk_step();
        n_cmp++;
        if (bus.state !== 2'd0 || bus.fan_off_req !== 1'b0 || bus.led !== 1'b0) begin
            n_err++;
            $display("FAIL post_expire: st=%0d req=%b led=%b, want 0/0/0", bus.state, bus.fan_off_req, bus.led);
        end
        n_cmp++;
        if (dut_req_cnt - req_before !== 1) begin
            n_err++;
            $display("FAIL req_pulses: got %0d, want 1", dut_req_cnt - req_before);
        end
    endtask

    task automatic test_cycling();
        int req_before = dut_req_cnt;
        arm();
        bus.btn_time = 1; clk_step();
        n_cmp++;
        if (bus.remaining !== 8'd60 || bus.state !== 2'd1) begin
            n_err++;
            $display("FAIL cycle1: rem=%0d st=%0d, want 60/1", bus.remaining, bus.state);
        end
        bus.btn_time = 1; clk_step();
        n_cmp++;
        if (bus.remaining !== 8'd120) begin
            n_err++;
            $display("FAIL cycle2: rem=%0d, want 120", bus.remaining);
        end
        bus.btn_time = 1; clk_step();
        n_cmp++;
        if (bus.state !== 2'd0 || bus.remaining !== 8'd0 || dut_req_cnt != req_before) begin
            n_err++;
            $display("FAIL cycle3_cancel: st=%0d rem=%0d reqs=%0d, want 0/0/0",
                     bus.state, bus.remaining, dut_req_cnt - req_before);
        end
    endtask

    task automatic test_simultaneous();
        arm();
        for (int i = 0; i < 3; i++) begin bus.tick_1s = 1; clk_step(); end
        bus.btn_time = 1; bus.tick_1s = 1; clk_step();
        n_cmp++;
        if (bus.remaining !== 8'd60 || bus.state !== 2'd1) begin
            n_err++;
            $display("FAIL time_beats_tick: rem=%0d st=%0d, want 60/1", bus.remaining, bus.state);
        end
        bus.btn_time = 1; bus.btn_cancel = 1; clk_step();
        n_cmp++;
        if (bus.state !== 2'd0 || bus.remaining !== 8'd0) begin
            n_err++;
            $display("FAIL cancel_beats_time: st=%0d rem=%0d, want 0/0", bus.state, bus.remaining);
        end
    endtask

    task automatic test_fan_off_in_warn();
        int req_before = dut_req_cnt;
        arm();
        for (int i = 0; i < 27; i++) begin bus.tick_1s = 1; clk_step(); end
        n_cmp++;
        if (bus.state !== 2'd2 || bus.remaining !== 8'd3) begin
            n_err++;
            $display("FAIL warn_at3: st=%0d rem=%0d, want 2/3", bus.state, bus.remaining);
        end
        bus.fan_on = 0; clk_step();
        n_cmp++;
        if (bus.state !== 2'd0 || bus.remaining !== 8'd0 || dut_req_cnt != req_before) begin
            n_err++;
            $display("FAIL fan_off_abort: st=%0d rem=%0d reqs=%0d, want 0/0/0",
                     bus.state, bus.remaining, dut_req_cnt - req_before);
        end
        bus.fan_on = 1; clk_step();
    endtask

    task automatic test_led_cadence();
        logic prev;
        int   toggles = 0;
        arm();
        prev = bus.led;
        bus.tick_250ms = 1; clk_step();
        n_cmp++;
        if (bus.led !== prev) begin
            n_err++;
            $display("FAIL run_250_ignored: led=%b, want %b", bus.led, prev);
        end
        bus.tick_500ms = 1; clk_step();
        n_cmp++;
        if (bus.led !== ~prev) begin
            n_err++;
            $display("FAIL run_500_toggle: led=%b, want %b", bus.led, ~prev);
        end
        for (int i = 0; i < 25; i++) begin bus.tick_1s = 1; clk_step(); end
        for (int i = 0; i < 4; i++) begin
            prev = bus.led;
            bus.tick_250ms = 1; bus.tick_500ms = (i == 0); clk_step();
            if (bus.led !== prev) toggles++;
            clk_step();
        end
        n_cmp++;
        if (toggles != 4 || bus.state !== 2'd2) begin
            n_err++;
            $display("FAIL warn_toggles: got %0d in st=%0d, want 4 in st=2", toggles, bus.state);
        end
        rst_n = 0; bus.tick_250ms = 1; bus.tick_1s = 1; clk_step();
        n_cmp++;
        if (bus.state !== 2'd0 || bus.remaining !== 8'd0 || bus.led !== 1'b0 || bus.fan_off_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_warn: st=%0d rem=%0d led=%b req=%b, want all 0",
                     bus.state, bus.remaining, bus.led, bus.fan_off_req);
        end
        rst_n = 1; clk_step();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 4000; i++) begin
            rst_n          = ($urandom_range(299) != 0);
            bus.btn_cancel = ($urandom_range(99) == 0);
            if ($urandom_range(79) == 0) bus.fan_on = ~bus.fan_on;
            if ($urandom_range(199) == 0) bus.fan_on = 1;
            bus.btn_time   = ($urandom_range(29) == 0);
            bus.tick_1s    = ($urandom_range(2) == 0);
            bus.tick_500ms = ($urandom_range(3) == 0);
            bus.tick_250ms = ($urandom_range(2) == 0);
            clk_step();
            n_cmp++;
            if (int'(bus.state) !== m_state || int'(bus.remaining) !== m_rem ||
                int'(bus.led) !== m_led || int'(bus.fan_off_req) !== m_req) begin
                n_err++;
                if (bad++ < 10)
                    $display("FAIL random cyc%0d: st=%0d rem=%0d led=%b req=%b, want %0d/%0d/%0d/%0d",
                             i, bus.state, bus.remaining, bus.led, bus.fan_off_req, m_state, m_rem, m_led, m_req);
            end
        end
        rst_n = 1;
        n_cmp++;
        if (dut_req_cnt != mdl_req_cnt) begin
            n_err++;
            $display("FAIL req_total: got %0d, want %0d", dut_req_cnt, mdl_req_cnt);
        end
    endtask

    initial begin
        rst_n = 0;
        bus.tick_1s = 0; bus.tick_500ms = 0; bus.tick_250ms = 0;
        bus.fan_on = 0; bus.btn_time = 0; bus.btn_cancel = 0;
        m_state = 0; m_rem = 0; m_led = 0; m_req = 0; m_sel = 0;
        dut_req_cnt = 0; mdl_req_cnt = 0;
        test_reset();
        test_full_countdown();
        test_cycling();
        test_simultaneous();
        test_fan_off_in_warn();
        test_led_cadence();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
